// File: rtl/rom_loader_pkg.sv
// Shared constants and types for the framed-image ROM loader.
package rom_loader_pkg;

    localparam int DEFAULT_ROM_ADDR_WIDTH = 10;

    localparam logic [7:0] ROM_LOADER_SYNC = 8'hA5;

    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        SYNC,
        LEN0,
        LEN1,
        DATA,
        WRITE,
        VERIFY,
        CSUM,
        DONE,
        ERROR
    } rom_loader_state_t;

endpackage

// File: rtl/rom_loader.sv
// Purpose: parse an A5/len/data/xor byte frame and program ROM words from address 0; optional ROM_LOADER_VERIFY_EN adds read-back.
// Latency: each ROM write issues 1 cycle after the 4th byte of its word is accepted; done pulses 1 cycle after the checksum byte.
// Backpressure: in_ready drops for 1 cycle per word (2 with ROM_LOADER_VERIFY_EN) and during DONE; bytes are otherwise always taken.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ROM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  rom_wr_en,
    output logic                  rom_rd_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic [31:0]           rom_wr_data,
    output logic [3:0]            rom_wr_strobe,
    input  logic [31:0]           rom_rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  hold_cpu
);

    // One extra index bit so a full-depth image can step past the last word without wrapping.
    localparam int          IW    = ADDR_WIDTH + 1;
    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_WIDTH);

    rom_loader_state_t state_q, state_d;
    logic [15:0]       count_q, count_d;
    logic [IW-1:0]     index_q, index_d;
    logic [1:0]        lane_q,  lane_d;
    word_t             word_q,  word_d;
    logic [7:0]        xor_q,   xor_d;

    logic        accept;
    logic [16:0] index_inc;
    logic        last_word;
    logic [15:0] len_full;

    assign accept    = in_valid & in_ready;
    assign index_inc = 17'(index_q) + 17'd1;
    assign last_word = (index_inc == {1'b0, count_q});
    assign len_full  = {in_data, count_q[7:0]};

`ifndef ROM_LOADER_VERIFY_EN
    logic unused_rd_data;
    assign unused_rd_data = ^rom_rd_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SYNC;
            count_q <= '0;
            index_q <= '0;
            lane_q  <= '0;
            word_q  <= '0;
            xor_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            index_q <= index_d;
            lane_q  <= lane_d;
            word_q  <= word_d;
            xor_q   <= xor_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        index_d = index_q;
        lane_d  = lane_q;
        word_d  = word_q;
        xor_d   = xor_q;
        case (state_q)
            // ERROR drains like SYNC; a sync byte restarts a fresh frame from either.
            SYNC, ERROR: begin
                if (accept && in_data == ROM_LOADER_SYNC) begin
                    state_d = LEN0;
                    count_d = '0;
                    index_d = '0;
                    lane_d  = '0;
                    word_d  = '0;
                    xor_d   = '0;
                end
            end
            LEN0: begin
                if (accept) begin
                    count_d[7:0] = in_data;
                    state_d      = LEN1;
                end
            end
            LEN1: begin
                if (accept) begin
                    count_d[15:8] = in_data;
                    if (len_full == 16'd0)
                        state_d = CSUM;
                    else if ({1'b0, len_full} > DEPTH)
                        state_d = ERROR;
                    else
                        state_d = DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    word_d[8*lane_q +: 8] = in_data;
                    xor_d                 = xor_q ^ in_data;
                    lane_d                = lane_q + 2'd1;
                    if (lane_q == 2'd3)
                        state_d = WRITE;
                end
            end
`ifdef ROM_LOADER_VERIFY_EN
            WRITE: state_d = VERIFY;
            VERIFY: begin
                if (rom_rd_data != word_q) begin
                    state_d = ERROR;
                end else begin
                    index_d = index_inc[IW-1:0];
                    state_d = last_word ? CSUM : DATA;
                end
            end
`else
            WRITE: begin
                index_d = index_inc[IW-1:0];
                state_d = last_word ? CSUM : DATA;
            end
`endif
            CSUM: begin
                if (accept)
                    state_d = (in_data == xor_q) ? DONE : ERROR;
            end
            DONE:    state_d = SYNC;
            default: state_d = SYNC;
        endcase
    end

    always_comb begin
        in_ready      = 1'b0;
        rom_wr_en     = 1'b0;
        rom_rd_en     = 1'b0;
        rom_wr_strobe = 4'h0;
        busy          = 1'b0;
        done          = 1'b0;
        error         = 1'b0;
        hold_cpu      = 1'b0;
        case (state_q)
            SYNC: in_ready = 1'b1;
            LEN0, LEN1, DATA, CSUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                hold_cpu = 1'b1;
            end
            WRITE: begin
                rom_wr_en     = 1'b1;
                rom_wr_strobe = 4'hF;
                busy          = 1'b1;
                hold_cpu      = 1'b1;
            end
`ifdef ROM_LOADER_VERIFY_EN
            VERIFY: begin
                rom_rd_en = 1'b1;
                busy      = 1'b1;
                hold_cpu  = 1'b1;
            end
`endif
            DONE: done = 1'b1;
            ERROR: begin
                in_ready = 1'b1;
                error    = 1'b1;
                hold_cpu = 1'b1;
            end
            default: ;
        endcase
    end

    assign rom_addr    = index_q[ADDR_WIDTH-1:0];
    assign rom_wr_data = word_q;

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader against a behavioural 16-word ROM: frame vectors, timing sequences and random frames.
module tb_rom_loader;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          rom_wr_en;
    logic          rom_rd_en;
    logic [AW-1:0] rom_addr;
    logic [31:0]   rom_wr_data;
    logic [3:0]    rom_wr_strobe;
    logic [31:0]   rom_rd_data;
    logic          busy;
    logic          done;
    logic          error;
    logic          hold_cpu;

    rom_loader #(.ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .rom_wr_en     (rom_wr_en),
        .rom_rd_en     (rom_rd_en),
        .rom_addr      (rom_addr),
        .rom_wr_data   (rom_wr_data),
        .rom_wr_strobe (rom_wr_strobe),
        .rom_rd_data   (rom_rd_data),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .hold_cpu      (hold_cpu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ROM with byte strobes and combinational read; rd_flip corrupts read-back.
    logic [31:0] rom_mem [DEPTH];
    logic        rom_clr;
    logic [31:0] rd_flip;

    always @(posedge clk) begin
        if (rom_clr) begin
            for (int i = 0; i < DEPTH; i++) rom_mem[i] <= 32'h0;
        end else if (rom_wr_en) begin
            for (int b = 0; b < 4; b++)
                if (rom_wr_strobe[b]) rom_mem[rom_addr][8*b +: 8] <= rom_wr_data[8*b +: 8];
        end
    end
    assign rom_rd_data = rom_mem[rom_addr] ^ rd_flip;

    int done_cnt = 0, wr_cnt = 0, rd_cnt = 0, proto_bad = 0;
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (rom_wr_en) wr_cnt++;
        if (rom_rd_en) rd_cnt++;
        if (rom_wr_en ? (rom_wr_strobe != 4'hF) : (rom_wr_strobe != 4'h0)) proto_bad++;
        if (done && (busy || hold_cpu || error)) proto_bad++;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_rom();
        rom_clr = 1'b1;
        @(negedge clk);
        rom_clr = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge just after the byte was taken.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int budget;
        budget = 0;
        if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready) begin
            @(negedge clk);
            budget++;
            if (budget > 50) begin
                errors++;
                $display("FAIL send_timeout: in_ready stuck low for byte %h", b);
                break;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    function automatic logic [127:0] lj(input int n, input logic [127:0] v);
        return v << (8 * (16 - n));
    endfunction

    typedef struct {
        bit          do_rst;
        int          n;
        logic [127:0] s;
        logic [31:0] r0;
        logic [31:0] r1;
        int          nd;
        int          nw;
        logic        er;
    } vec_t;

    vec_t        vt [7];
    logic [31:0] model [DEPTH];
    logic [31:0] words [DEPTH];

    initial begin
        int d0, w0, cnt, ng;
        logic [7:0] x, cs, g;
        bit big, ok, exp_done;

        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; rom_clr = 1'b0; rd_flip = 32'h0;

        vt[0] = '{1'b1, 12, lj(12, 128'({8'hA5,8'h02,8'h00,8'h11,8'h22,8'h33,8'h44,8'h55,8'h66,8'h77,8'h88,8'h88})),
                  32'h44332211, 32'h88776655, 1, 2, 1'b0};
        vt[1] = '{1'b1, 11, lj(11, 128'({8'h00,8'hFF,8'hA4,8'hA5,8'h01,8'h00,8'hEF,8'hBE,8'hAD,8'hDE,8'h22})),
                  32'hDEADBEEF, 32'h0, 1, 1, 1'b0};
        vt[2] = '{1'b1, 3, lj(3, 128'({8'hA5,8'h11,8'h00})), 32'h0, 32'h0, 0, 0, 1'b1};
        vt[3] = '{1'b0, 4, lj(4, 128'({8'hA5,8'h00,8'h00,8'h00})), 32'h0, 32'h0, 1, 0, 1'b0};
        vt[4] = '{1'b1, 8, lj(8, 128'({8'hA5,8'h01,8'h00,8'h01,8'h02,8'h03,8'h04,8'hFF})),
                  32'h04030201, 32'h0, 0, 1, 1'b1};
        vt[5] = '{1'b1, 4, lj(4, 128'({8'hA5,8'h00,8'h00,8'h01})), 32'h0, 32'h0, 0, 0, 1'b1};
        vt[6] = '{1'b1, 8, lj(8, 128'({8'hA5,8'h01,8'h00,8'hA5,8'hA5,8'hA5,8'hA5,8'h00})),
                  32'hA5A5A5A5, 32'h0, 1, 1, 1'b0};

        @(negedge clk);
        do_reset();
        clear_rom();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_hold", 32'(hold_cpu), 32'd0);
        chk("rst_wr_en", 32'(rom_wr_en), 32'd0);
        chk("rst_rd_en", 32'(rom_rd_en), 32'd0);
        chk("rst_addr", 32'(rom_addr), 32'd0);
        chk("rst_strobe", 32'(rom_wr_strobe), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        for (int t = 0; t < 7; t++) begin
            if (vt[t].do_rst) do_reset();
            clear_rom();
            d0 = done_cnt; w0 = wr_cnt;
            for (int i = 0; i < vt[t].n; i++) send_byte(vt[t].s[127 - 8*i -: 8], 1'b1);
            settle();
            chk($sformatf("vec%0d_rom0", t), rom_mem[0], vt[t].r0);
            chk($sformatf("vec%0d_rom1", t), rom_mem[1], vt[t].r1);
            chk($sformatf("vec%0d_done", t), 32'(done_cnt - d0), 32'(vt[t].nd));
            chk($sformatf("vec%0d_writes", t), 32'(wr_cnt - w0), 32'(vt[t].nw));
            chk($sformatf("vec%0d_error", t), 32'(error), 32'(vt[t].er));
            chk($sformatf("vec%0d_hold", t), 32'(hold_cpu), 32'(vt[t].er));
            chk($sformatf("vec%0d_busy", t), 32'(busy), 32'd0);
        end

        // Write lands the cycle after the 4th byte is taken.
        do_reset();
        clear_rom();
        send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b0);
        in_valid = 1'b1; in_data = 8'h44;
        chk("t_ready_lane3", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("t_wr_en", 32'(rom_wr_en), 32'd1);
        chk("t_wr_addr", 32'(rom_addr), 32'd0);
        chk("t_wr_data", rom_wr_data, 32'h44332211);
        chk("t_wr_strobe", 32'(rom_wr_strobe), 32'hF);
        chk("t_wr_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
`ifdef ROM_LOADER_VERIFY_EN
        chk("t_vfy_rd_en", 32'(rom_rd_en), 32'd1);
        chk("t_vfy_wr_en", 32'(rom_wr_en), 32'd0);
        chk("t_vfy_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
`endif
        chk("t_post_wr_en", 32'(rom_wr_en), 32'd0);
        chk("t_post_ready", 32'(in_ready), 32'd1);
        chk("t_post_busy", 32'(busy), 32'd1);
        send_byte(8'h44, 1'b0);
        chk("t_done", 32'(done), 32'd1);
        chk("t_done_hold", 32'(hold_cpu), 32'd0);
        chk("t_done_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("t_done_pulse", 32'(done), 32'd0);

        // rst in the middle of word 1 of a 3-word frame.
        do_reset();
        clear_rom();
        send_byte(8'hA5, 1'b1); send_byte(8'h03, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
        send_byte(8'h05, 1'b1); send_byte(8'h06, 1'b1);
        chk("mr_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_hold", 32'(hold_cpu), 32'd0);
        chk("mr_error", 32'(error), 32'd0);
        chk("mr_addr", 32'(rom_addr), 32'd0);
        chk("mr_rom0", rom_mem[0], 32'h04030201);
        chk("mr_rom1", rom_mem[1], 32'h0);
        d0 = done_cnt;
        send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h0D, 1'b1); send_byte(8'hF0, 1'b1); send_byte(8'hFE, 1'b1); send_byte(8'hCA, 1'b1);
        send_byte(8'hC9, 1'b1);
        settle();
        chk("mr_fresh_rom0", rom_mem[0], 32'hCAFEF00D);
        chk("mr_fresh_done", 32'(done_cnt - d0), 32'd1);

`ifdef ROM_LOADER_VERIFY_EN
        do_reset();
        clear_rom();
        rd_flip = 32'h0000_0001;
        send_byte(8'hA5, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h10, 1'b0); send_byte(8'h20, 1'b0); send_byte(8'h30, 1'b0); send_byte(8'h40, 1'b0);
        @(negedge clk);
        chk("v_rd_en", 32'(rom_rd_en), 32'd1);
        @(negedge clk);
        chk("v_error", 32'(error), 32'd1);
        chk("v_hold", 32'(hold_cpu), 32'd1);
        rd_flip = 32'h0;
        w0 = wr_cnt;
        for (int i = 0; i < 5; i++) send_byte(8'h5A, 1'b1);
        settle();
        chk("v_drain_error", 32'(error), 32'd1);
        chk("v_drain_writes", 32'(wr_cnt - w0), 32'd0);
`else
        chk("nv_rd_en_never", 32'(rd_cnt), 32'd0);
`endif

        // Random frames against a frame-level image model.
        do_reset();
        clear_rom();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        for (int r = 0; r < 20; r++) begin
            ng = $urandom_range(0, 3);
            for (int i = 0; i < ng; i++) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h00;
                send_byte(g, 1'b1);
            end
            cnt = (r == 0) ? DEPTH : $urandom_range(0, DEPTH + 2);
            big = (cnt > DEPTH);
            ok  = ($urandom_range(0, 3) != 0);
            d0 = done_cnt; w0 = wr_cnt;
            send_byte(8'hA5, 1'b1); send_byte(8'(cnt), 1'b1); send_byte(8'h00, 1'b1);
            if (!big) begin
                x = 8'h00;
                for (int w = 0; w < cnt; w++) begin
                    words[w] = $urandom;
                    for (int b = 0; b < 4; b++) begin
                        x = x ^ words[w][8*b +: 8];
                        send_byte(words[w][8*b +: 8], 1'b1);
                    end
                    model[w] = words[w];
                end
                cs = ok ? x : (x ^ (8'h01 << $urandom_range(0, 7)));
                send_byte(cs, 1'b1);
            end
            exp_done = !big && ok;
            settle();
            chk($sformatf("rnd%0d_done", r), 32'(done_cnt - d0), 32'(exp_done));
            chk($sformatf("rnd%0d_error", r), 32'(error), 32'(!exp_done));
            chk($sformatf("rnd%0d_writes", r), 32'(wr_cnt - w0), big ? 32'd0 : 32'(cnt));
            for (int i = 0; i < DEPTH; i++)
                chk($sformatf("rnd%0d_rom%0d", r, i), rom_mem[i], model[i]);
        end

        chk("protocol_violations", 32'(proto_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
